// File: rtl/game_state_rx.sv
// game_state_rx
//   Receive-side decoder for the inter-board game-state link. Reassembles the
//   7-byte frame SYNC, X_HI, X_LO, Y_HI, Y_LO, PTS, CHK from the UART byte
//   stream. The remote point position and score change only when a complete
//   frame has been validated, and all three change on the same edge.
//
//   Ports
//     clk        system clock
//     rst        synchronous, active-high reset
//     rx_data    received byte, valid while rx_valid is high
//     rx_valid   single-cycle strobe, one per received byte
//     point_x    remote point x position (10 bits)
//     point_y    remote point y position (10 bits)
//     points     remote score (5 bits)
//     frame_ok   1-cycle pulse: good frame accepted, outputs updated
//     frame_err  1-cycle pulse: frame discarded (bad check, reserved bits, timeout)
//     link_up    a good frame was seen within the last LINK_TIMEOUT cycles
module game_state_rx #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned BYTE_TIMEOUT = 50_000,
  parameter int unsigned LINK_TIMEOUT = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [9:0] point_x,
  output logic [9:0] point_y,
  output logic [4:0] points,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       link_up
);

  localparam int BW = $clog2(BYTE_TIMEOUT) + 1;
  localparam int LW = $clog2(LINK_TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, XH, XL, YH, YL, PT, CK} state_t;

  state_t        state;
  logic [BW-1:0] byte_cnt;
  logic [LW-1:0] link_cnt;
  logic [7:0]    chk;
  logic          rsv_bad;
  logic [1:0]    x_hi;
  logic [7:0]    x_lo;
  logic [1:0]    y_hi;
  logic [7:0]    y_lo;
  logic [4:0]    pts;

  logic byte_expire;
  logic accept;

  // The expiry cycle is the BYTE_TIMEOUT-th cycle without a byte; a byte
  // arriving in that same cycle takes priority, so the frame continues.
  assign byte_expire = (state != IDLE) && !rx_valid &&
                       (byte_cnt == BW'(BYTE_TIMEOUT - 1));
  assign accept      = rx_valid && (state == CK) && (rx_data == chk) && !rsv_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      link_cnt  <= '0;
      chk       <= '0;
      rsv_bad   <= 1'b0;
      x_hi      <= '0;
      x_lo      <= '0;
      y_hi      <= '0;
      y_lo      <= '0;
      pts       <= '0;
      point_x   <= 10'd512;
      point_y   <= 10'd64;
      points    <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      link_up   <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      // Inter-byte gap counter: parked at zero outside a frame.
      if (state == IDLE || rx_valid || byte_expire) byte_cnt <= '0;
      else                                          byte_cnt <= byte_cnt + 1'b1;

      if (rx_valid) begin
        case (state)
          IDLE: if (rx_data == SYNC_BYTE) state <= XH;
          XH: begin
            x_hi    <= rx_data[1:0];
            rsv_bad <= |rx_data[7:2];
            chk     <= rx_data;          // first payload byte seeds the checksum
            state   <= XL;
          end
          XL: begin
            x_lo  <= rx_data;
            chk   <= chk ^ rx_data;
            state <= YH;
          end
          YH: begin
            y_hi    <= rx_data[1:0];
            rsv_bad <= rsv_bad | (|rx_data[7:2]);
            chk     <= chk ^ rx_data;
            state   <= YL;
          end
          YL: begin
            y_lo  <= rx_data;
            chk   <= chk ^ rx_data;
            state <= PT;
          end
          PT: begin
            pts     <= rx_data[4:0];
            rsv_bad <= rsv_bad | (|rx_data[7:5]);
            chk     <= chk ^ rx_data;
            state   <= CK;
          end
          CK: begin
            state <= IDLE;
            if (accept) begin
              point_x  <= {x_hi, x_lo};
              point_y  <= {y_hi, y_lo};
              points   <= pts;
              frame_ok <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (byte_expire) begin
        frame_err <= 1'b1;
        state     <= IDLE;
      end

      // Link watchdog: an accept in the expiry cycle wins and keeps link_up.
      if (accept) begin
        link_cnt <= '0;
        link_up  <= 1'b1;
      end else if (link_cnt != LW'(LINK_TIMEOUT)) begin
        link_cnt <= link_cnt + 1'b1;
        if (link_cnt == LW'(LINK_TIMEOUT - 1)) link_up <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_game_state_rx.sv
// Testbench for game_state_rx. Frames are built by the bench, the expected
// outcome of each frame is queued when it is sent, and a monitor pops and
// compares on every frame_ok / frame_err pulse.
module tb_game_state_rx;

  localparam int BT = 20;
  localparam int LT = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [9:0] point_x;
  logic [9:0] point_y;
  logic [4:0] points;
  logic       frame_ok;
  logic       frame_err;
  logic       link_up;

  game_state_rx #(
    .SYNC_BYTE   (8'hA5),
    .BYTE_TIMEOUT(BT),
    .LINK_TIMEOUT(LT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .point_x  (point_x),
    .point_y  (point_y),
    .points   (points),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .link_up  (link_up)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         ok;
    logic [9:0] x;
    logic [9:0] y;
    logic [4:0] p;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] m_x = 10'd512;
  logic [9:0] m_y = 10'd64;
  logic [4:0] m_p = 5'd0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] mk_frame(input logic [9:0] x, input logic [9:0] y,
                                           input logic [4:0] p);
    logic [7:0] xh, xl, yh, yl, pt;
    xh = {6'b0, x[9:8]};
    xl = x[7:0];
    yh = {6'b0, y[9:8]};
    yl = y[7:0];
    pt = {3'b0, p};
    return {8'hA5, xh, xl, yh, yl, pt, xh ^ xl ^ yh ^ yl ^ pt};
  endfunction

  task automatic push_exp(input bit ok, input logic [9:0] x, input logic [9:0] y,
                          input logic [4:0] p);
    exp_t e;
    if (ok) begin
      m_x = x;
      m_y = y;
      m_p = p;
    end
    e.ok = ok;
    e.x  = m_x;
    e.y  = m_y;
    e.p  = m_p;
    sb_q.push_back(e);
  endtask

  // Called just after a posedge (+#1); leaves the bench in the same phase.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send7(input logic [55:0] f, input int gap);
    for (int i = 6; i >= 0; i--) begin
      send_byte(f[i*8 +: 8]);
      if (i != 0 && gap > 0) idle(gap);
    end
  endtask

  task automatic report(input string what);
    $display("txn %s: x=%0d y=%0d pts=%0d link_up=%0d", what, point_x, point_y, points, link_up);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && (frame_ok || frame_err)) begin
      check_val("pulse_exclusive", {31'b0, frame_ok & frame_err}, 32'd0);
      if (sb_q.size() == 0) begin
        check_val("spurious_pulse", {30'b0, frame_ok, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("frame_ok", {31'b0, frame_ok}, {31'b0, e.ok});
        check_val("frame_err", {31'b0, frame_err}, {31'b0, !e.ok});
        check_val("point_x", {22'b0, point_x}, {22'b0, e.x});
        check_val("point_y", {22'b0, point_y}, {22'b0, e.y});
        check_val("points", {27'b0, points}, {27'b0, e.p});
      end
    end
  end

  task automatic check_outputs(input string tag);
    @(negedge clk);
    check_val({tag, "_x"}, {22'b0, point_x}, {22'b0, m_x});
    check_val({tag, "_y"}, {22'b0, point_y}, {22'b0, m_y});
    check_val({tag, "_p"}, {27'b0, points}, {27'b0, m_p});
    report(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [55:0] f;
    logic [9:0]  rx, ry;
    logic [4:0]  rp;
    bit          bad;
    int          cnt;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_frame_ok", {31'b0, frame_ok}, 32'd0);
    check_val("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check_val("rst_link_up", {31'b0, link_up}, 32'd0);
    @(posedge clk);
    #1;
    check_outputs("reset");

    // Bad checksum
    push_exp(1'b0, 0, 0, 0);
    send7(56'hA5_01_E0_01_60_11_90, 0);
    idle(2);
    check_outputs("bad_chk");
    @(negedge clk);
    check_val("link_after_bad", {31'b0, link_up}, 32'd0);
    @(posedge clk);
    #1;

    // Reserved bit set in X_HI with consistent checksum
    push_exp(1'b0, 0, 0, 0);
    send7(56'hA5_05_E0_01_60_11_95, 1);
    idle(2);
    check_outputs("rsv_bit");

    // Reserved bit set in PTS
    push_exp(1'b0, 0, 0, 0);
    send7(56'hA5_01_E0_01_60_31_B1, 0);
    idle(2);
    check_outputs("rsv_pts");

    // Reference good frame, frame_ok one cycle after the last byte
    push_exp(1'b1, 10'd480, 10'd352, 5'd17);
    send7(56'hA5_01_E0_01_60_11_91, 0);
    @(negedge clk);
    check_val("ok_latency", {31'b0, frame_ok}, 32'd1);
    check_val("link_up_on_ok", {31'b0, link_up}, 32'd1);
    @(posedge clk);
    #1;
    check_outputs("frame_a");

    // Leading junk bytes are ignored
    send_byte(8'h3C);
    send_byte(8'h7F);
    f = mk_frame(10'd100, 10'd900, 5'd5);
    push_exp(1'b1, 10'd100, 10'd900, 5'd5);
    send7(f, 1);
    idle(2);
    check_outputs("junk_lead");

    // Sync value inside payload is plain data
    f = mk_frame(10'd165, 10'd3, 5'd31);
    push_exp(1'b1, 10'd165, 10'd3, 5'd31);
    send7(f, 0);
    idle(2);
    check_outputs("sync_in_payload");

    // Inter-byte timeout
    push_exp(1'b0, 0, 0, 0);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hE0);
    idle(BT);
    idle(2);
    f = mk_frame(10'd7, 10'd8, 5'd9);
    push_exp(1'b1, 10'd7, 10'd8, 5'd9);
    send7(f, 0);
    idle(2);
    check_outputs("after_timeout");

    // Gap one cycle short of the timeout must not expire
    f = mk_frame(10'd1023, 10'd512, 5'd16);
    push_exp(1'b1, 10'd1023, 10'd512, 5'd16);
    send7(f, BT - 1);
    idle(2);
    check_outputs("gap_boundary");

    // Back-to-back frames with no idle gap
    push_exp(1'b1, 10'd11, 10'd22, 5'd3);
    push_exp(1'b1, 10'd33, 10'd44, 5'd4);
    send7(mk_frame(10'd11, 10'd22, 5'd3), 0);
    send7(mk_frame(10'd33, 10'd44, 5'd4), 0);
    idle(2);
    check_outputs("back_to_back");

    // Randomised frames, about a quarter with a corrupted checksum
    for (int i = 0; i < 10; i++) begin
      rx  = 10'($urandom_range(0, 1023));
      ry  = 10'($urandom_range(0, 1023));
      rp  = 5'($urandom_range(0, 31));
      bad = ($urandom_range(0, 3) == 0);
      f   = mk_frame(rx, ry, rp);
      if (bad) f[7:0] = f[7:0] ^ 8'(1 << $urandom_range(0, 7));
      push_exp(!bad, rx, ry, rp);
      send7(f, $urandom_range(0, 2));
      idle(1);
    end
    idle(2);
    check_outputs("random");

    // Link timeout: link_up stays high for exactly LT cycles
    push_exp(1'b1, 10'd200, 10'd300, 5'd10);
    send7(mk_frame(10'd200, 10'd300, 5'd10), 0);
    @(negedge clk);
    cnt = 0;
    while (link_up && cnt < LT + 10) begin
      cnt++;
      @(negedge clk);
    end
    check_val("link_up_len", cnt, LT);
    repeat (5) @(negedge clk);
    check_val("link_stays_down", {31'b0, link_up}, 32'd0);
    $display("txn link_timeout: link_up high for %0d cycles", cnt);
    @(posedge clk);
    #1;

    // Reset in the middle of a frame: silent discard, outputs back to defaults
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hE0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_x = 10'd512;
    m_y = 10'd64;
    m_p = 5'd0;
    check_outputs("mid_rst");
    @(negedge clk);
    check_val("mid_rst_link", {31'b0, link_up}, 32'd0);
    @(posedge clk);
    #1;
    f = mk_frame(10'd480, 10'd352, 5'd17);
    push_exp(1'b1, 10'd480, 10'd352, 5'd17);
    send7(f, 0);
    idle(3);
    check_outputs("post_rst_frame");

    check_val("pending_expected", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
